// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Byte-serial instruction fetch engine. On a start pulse it reads four
// consecutive bytes over a req/ack memory handshake, assembles them
// little-endian into a 32-bit instruction and presents it with a one-cycle
// done pulse. A per-byte watchdog aborts a fetch whose request is never
// acknowledged and reports it with a one-cycle fault pulse.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous reset, active low
//   start      begin a fetch at pc (sampled only while idle)
//   pc         byte address of the instruction's first byte
//   mem_req    read request, held until acknowledged
//   mem_addr   byte address of the current request
//   mem_rdata  read data, valid with mem_ack
//   mem_ack    one-cycle read acknowledge
//   instr      last successfully fetched instruction
//   op         instr[31:26]
//   funct      instr[5:0]
//   busy       high whenever a fetch is in progress (state not IDLE)
//   done       one-cycle pulse, instr already holds the new value
//   fault      one-cycle pulse, fetch aborted by the watchdog
module instr_fetch_unit #(
   parameter int AW      = 8,
   parameter int TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [AW-1:0] pc,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   input  logic [7:0]    mem_rdata,
   input  logic          mem_ack,
   output logic [31:0]   instr,
   output logic [5:0]    op,
   output logic [5:0]    funct,
   output logic          busy,
   output logic          done,
   output logic          fault
);

   localparam int WW = $clog2(TIMEOUT + 1);
   localparam logic [WW-1:0] WCNT_LAST = WW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, REQ, DONE, FAULT} state_t;

   state_t        state_reg, state_next;
   logic [AW-1:0] base_reg,  base_next;
   logic [1:0]    idx_reg,   idx_next;
   logic [WW-1:0] wcnt_reg,  wcnt_next;
   logic [31:0]   shadow_reg, shadow_next;
   logic [31:0]   instr_reg;
   logic          byte_we;
   logic          instr_we;

   // Next-state and datapath control
   always_comb begin
      state_next = state_reg;
      base_next  = base_reg;
      idx_next   = idx_reg;
      wcnt_next  = wcnt_reg;
      byte_we    = 1'b0;
      instr_we   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               base_next  = pc;
               idx_next   = 2'd0;
               wcnt_next  = '0;
               state_next = REQ;
            end
         end
         REQ: begin
            if (mem_ack) begin
               // An ack always wins over the watchdog, even on the last
               // allowed wait cycle.
               byte_we   = 1'b1;
               wcnt_next = '0;
               if (idx_reg == 2'd3) begin
                  instr_we   = 1'b1;
                  state_next = DONE;
               end else begin
                  idx_next = idx_reg + 2'd1;
               end
            end else if (wcnt_reg == WCNT_LAST) begin
               state_next = FAULT;
            end else begin
               wcnt_next = wcnt_reg + WW'(1);
            end
         end
         DONE:    state_next = IDLE;
         FAULT:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Byte lane steering: only the lane selected by idx takes the ack data.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign shadow_next[8*gi +: 8] = (byte_we && (idx_reg == 2'(gi)))
                                         ? mem_rdata
                                         : shadow_reg[8*gi +: 8];
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg  <= IDLE;
         base_reg   <= '0;
         idx_reg    <= 2'd0;
         wcnt_reg   <= '0;
         shadow_reg <= '0;
         instr_reg  <= '0;
      end else begin
         state_reg  <= state_next;
         base_reg   <= base_next;
         idx_reg    <= idx_next;
         wcnt_reg   <= wcnt_next;
         shadow_reg <= shadow_next;
         // Load from shadow_next so the fourth byte lands in instr on the
         // same edge that enters DONE.
         if (instr_we) begin
            instr_reg <= shadow_next;
         end
      end
   end

   // All outputs decode from registered state only.
   assign mem_req  = (state_reg == REQ);
   assign mem_addr = mem_req ? (base_reg + AW'(idx_reg)) : '0;
   assign busy     = (state_reg != IDLE);
   assign done     = (state_reg == DONE);
   assign fault    = (state_reg == FAULT);
   assign instr    = instr_reg;
   assign op       = instr_reg[31:26];
   assign funct    = instr_reg[5:0];

endmodule
